// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and pixel types
package vga_pkg;
    localparam int CNT_W_DEF   = 12;
    localparam int PIX_W       = 24;
    localparam int H_TOTAL_640 = 800;
    localparam int H_ACT_640   = 640;
    localparam int V_TOTAL_480 = 525;
    localparam int V_ACT_480   = 480;

    typedef logic [PIX_W-1:0] pixel_t;
endpackage

// File: rtl/vga_capture_monitor_edge_det.sv
// rtl/vga_capture_monitor_edge_det.sv - registered departure-from-idle detector with load enable
module vga_edge_det #(
    parameter bit IDLE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic din,
    output logic active_edge
);
    logic din_q;
    logic din_d;

    always_comb begin
        din_d = din_q;
        if (en) begin
            din_d = din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            din_q <= IDLE;
        end else begin
            din_q <= din_d;
        end
    end

    assign active_edge = (din != IDLE) && (din_q == IDLE);
endmodule

// File: rtl/vga_capture_monitor.sv
// rtl/vga_capture_monitor.sv - VGA stream timing measurement, frame checksum and lock detection
module vga_capture_monitor
    import vga_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int LOCK_FRAMES = 2,
    parameter bit SYNC_ACT    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vga_clock,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             blank,
    input  logic [PIX_W-1:0] rgb,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_active,
    output logic [PIX_W-1:0] frame_sum,
    output logic             frame_done,
    output logic             locked,
    output logic             err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic pix_en, h_edge, v_edge, h_start, v_start;

    vga_edge_det #(.IDLE(1'b0)) u_pix_det (
        .clk(clk), .reset(reset), .en(1'b1), .din(vga_clock), .active_edge(pix_en));
    vga_edge_det #(.IDLE(!SYNC_ACT)) u_hs_det (
        .clk(clk), .reset(reset), .en(pix_en), .din(hsync), .active_edge(h_edge));
    vga_edge_det #(.IDLE(!SYNC_ACT)) u_vs_det (
        .clk(clk), .reset(reset), .en(pix_en), .din(vsync), .active_edge(v_edge));

    assign h_start = pix_en && h_edge;
    assign v_start = pix_en && v_edge;

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, ha_cnt_q, ha_cnt_d, v_cnt_q, v_cnt_d, va_cnt_q, va_cnt_d;
    logic [CNT_W-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
    logic [CNT_W-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
    logic [CNT_W-1:0] prev_ht_q, prev_ht_d, prev_ha_q, prev_ha_d;
    pixel_t           sum_acc_q, sum_acc_d, frame_sum_q, frame_sum_d;
    logic             lha_q, lha_d, armed_q, armed_d, have_prev_q, have_prev_d;
    logic             frame_done_q, frame_done_d, locked_q, locked_d, err_q, err_d;
    logic [3:0]       stable_q, stable_d;
    logic [CNT_W-1:0] v_line, va_line;
    logic             match;

    // Vertical counts with the ending line folded in, for a frame latch on the same pixel.
    assign v_line  = h_start ? sat_inc(v_cnt_q) : v_cnt_q;
    assign va_line = (h_start && lha_q) ? sat_inc(va_cnt_q) : va_cnt_q;

    always_comb begin
        h_cnt_d      = h_cnt_q;
        ha_cnt_d     = ha_cnt_q;
        v_cnt_d      = v_cnt_q;
        va_cnt_d     = va_cnt_q;
        h_total_d    = h_total_q;
        h_active_d   = h_active_q;
        v_total_d    = v_total_q;
        v_active_d   = v_active_q;
        prev_ht_d    = prev_ht_q;
        prev_ha_d    = prev_ha_q;
        sum_acc_d    = sum_acc_q;
        frame_sum_d  = frame_sum_q;
        lha_d        = lha_q;
        armed_d      = armed_q;
        have_prev_d  = have_prev_q;
        locked_d     = locked_q;
        stable_d     = stable_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        match        = 1'b0;

        if (pix_en) begin
            h_cnt_d = sat_inc(h_cnt_q);
            if (blank) begin
                ha_cnt_d  = sat_inc(ha_cnt_q);
                lha_d     = 1'b1;
                sum_acc_d = sum_acc_q + rgb;
            end
            if (h_start) begin
                h_total_d  = h_cnt_q;
                h_active_d = ha_cnt_q;
                h_cnt_d    = CNT_W'(1);
                ha_cnt_d   = {{(CNT_W-1){1'b0}}, blank};
                v_cnt_d    = v_line;
                va_cnt_d   = va_line;
                lha_d      = blank;
            end
        end

        if (v_start) begin
            v_cnt_d   = '0;
            va_cnt_d  = '0;
            sum_acc_d = blank ? rgb : '0;
            if (!armed_q) begin
                armed_d = 1'b1;
            end else begin
                v_total_d    = v_line;
                v_active_d   = va_line;
                frame_sum_d  = sum_acc_q;
                frame_done_d = 1'b1;
                prev_ht_d    = h_total_d;
                prev_ha_d    = h_active_d;
                have_prev_d  = 1'b1;
                // A saturated measurement is never trusted as a match.
                match = have_prev_q && (h_total_d == prev_ht_q) && (h_active_d == prev_ha_q)
                     && (v_line == v_total_q) && (va_line == v_active_q)
                     && (v_line != CNT_MAX) && (h_total_d != CNT_MAX);
                if (match) begin
                    stable_d = (stable_q == LOCK_N) ? stable_q : stable_q + 1'b1;
                    locked_d = (stable_d == LOCK_N);
                end else begin
                    stable_d = '0;
                    locked_d = 1'b0;
                    err_d    = locked_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_cnt_q      <= '0;
            ha_cnt_q     <= '0;
            v_cnt_q      <= '0;
            va_cnt_q     <= '0;
            h_total_q    <= '0;
            h_active_q   <= '0;
            v_total_q    <= '0;
            v_active_q   <= '0;
            prev_ht_q    <= '0;
            prev_ha_q    <= '0;
            sum_acc_q    <= '0;
            frame_sum_q  <= '0;
            lha_q        <= 1'b0;
            armed_q      <= 1'b0;
            have_prev_q  <= 1'b0;
            frame_done_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            stable_q     <= '0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            ha_cnt_q     <= ha_cnt_d;
            v_cnt_q      <= v_cnt_d;
            va_cnt_q     <= va_cnt_d;
            h_total_q    <= h_total_d;
            h_active_q   <= h_active_d;
            v_total_q    <= v_total_d;
            v_active_q   <= v_active_d;
            prev_ht_q    <= prev_ht_d;
            prev_ha_q    <= prev_ha_d;
            sum_acc_q    <= sum_acc_d;
            frame_sum_q  <= frame_sum_d;
            lha_q        <= lha_d;
            armed_q      <= armed_d;
            have_prev_q  <= have_prev_d;
            frame_done_q <= frame_done_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            stable_q     <= stable_d;
        end
    end

    assign h_total    = h_total_q;
    assign h_active   = h_active_q;
    assign v_total    = v_total_q;
    assign v_active   = v_active_q;
    assign frame_sum  = frame_sum_q;
    assign frame_done = frame_done_q;
    assign locked     = locked_q;
    assign err        = err_q;
endmodule

// File: tb/tb_vga_capture_monitor.sv
// tb/tb_vga_capture_monitor.sv - table-driven bench for vga_capture_monitor
module tb_vga_capture_monitor;
    logic        clk = 1'b0;
    logic        reset;
    logic        vga_clock, hsync, vsync, blank;
    logic [23:0] rgb;
    logic [11:0] h_total, h_active, v_total, v_active;
    logic [23:0] frame_sum;
    logic        frame_done, locked, err;

    always #5 clk = ~clk;

    vga_capture_monitor dut (
        .clk(clk), .reset(reset), .vga_clock(vga_clock), .hsync(hsync), .vsync(vsync),
        .blank(blank), .rgb(rgb), .h_total(h_total), .h_active(h_active),
        .v_total(v_total), .v_active(v_active), .frame_sum(frame_sum),
        .frame_done(frame_done), .locked(locked), .err(err));

    typedef struct {
        int          h_tot, h_act, v_tot, v_act, pat;
        bit          short_last;
        logic [11:0] e_ht, e_ha, e_vt, e_va;
        logic [23:0] e_sum;
        logic        e_lock, e_err;
    } vec_t;

    vec_t        tbl[13];
    int          tests = 0, fails = 0;
    int          done_cnt = 0, err_cnt = 0;
    logic [11:0] cap_ht, cap_ha, cap_vt, cap_va;
    logic [23:0] cap_sum;
    logic        cap_lock;

    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt++;
            cap_ht = h_total; cap_ha = h_active; cap_vt = v_total; cap_va = v_active;
            cap_sum = frame_sum; cap_lock = locked;
        end
        if (err) err_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int pat, input int x, input int y);
        if (pat == 0) return 24'hFFFFFF;
        return ((((x / 4) + (y / 2)) % 2) == 1) ? 24'h00FF00 : 24'h0000FF;
    endfunction

    task automatic send_pixel(input logic hs, input logic vs, input logic bl, input logic [23:0] d);
        hsync = hs; vsync = vs; blank = bl; rgb = d; vga_clock = 1'b1;
        @(posedge clk); #1;
        vga_clock = 1'b0;
        @(posedge clk); #1;
    endtask

    // Line 0 pixel 0 carries both sync edges; it is sent separately as the frame boundary.
    task automatic send_start();
        send_pixel(1'b0, 1'b0, 1'b0, 24'h5A5A5A);
    endtask

    task automatic send_lines(input vec_t r, input int first, input int last);
        int  len;
        bit  act;
        for (int ln = first; ln <= last; ln++) begin
            len = (r.short_last && ln == r.v_tot - 1) ? r.h_tot - 1 : r.h_tot;
            for (int px = 0; px < len; px++) begin
                if (!(ln == 0 && px == 0)) begin
                    act = (ln >= r.v_tot - r.v_act) && (px >= 2) && (px < 2 + r.h_act);
                    send_pixel(px >= 2, ln >= 2, act,
                               act ? pix(r.pat, px - 2, ln - (r.v_tot - r.v_act)) : 24'h5A5A5A);
                end
            end
        end
    endtask

    task automatic check_frame(input string tag, input vec_t r, input int d0, input int e0);
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_err"},  err_cnt - e0, {31'd0, r.e_err});
        check({tag, "_ht"},   cap_ht, r.e_ht);
        check({tag, "_ha"},   cap_ha, r.e_ha);
        check({tag, "_vt"},   cap_vt, r.e_vt);
        check({tag, "_va"},   cap_va, r.e_va);
        check({tag, "_sum"},  cap_sum, r.e_sum);
        check({tag, "_lock"}, cap_lock, r.e_lock);
    endtask

    initial begin
        int d0, e0;
        tbl[0]  = '{20, 16, 12,   8, 0, 0, 12'd20, 12'd16, 12'd12,   12'd8, 24'hFFFF80, 1'b0, 1'b0};
        tbl[1]  = '{20, 16, 12,   8, 0, 0, 12'd20, 12'd16, 12'd12,   12'd8, 24'hFFFF80, 1'b0, 1'b0};
        tbl[2]  = '{20, 16, 12,   8, 1, 0, 12'd20, 12'd16, 12'd12,   12'd8, 24'h3FFFC0, 1'b1, 1'b0};
        tbl[3]  = '{20, 16, 12,   8, 1, 0, 12'd20, 12'd16, 12'd12,   12'd8, 24'h3FFFC0, 1'b1, 1'b0};
        tbl[4]  = '{20, 16, 12,   8, 0, 1, 12'd19, 12'd16, 12'd12,   12'd8, 24'hFFFF80, 1'b0, 1'b1};
        tbl[5]  = '{20, 16, 12,   8, 0, 0, 12'd20, 12'd16, 12'd12,   12'd8, 24'hFFFF80, 1'b0, 1'b0};
        tbl[6]  = '{20, 16, 12,   8, 0, 0, 12'd20, 12'd16, 12'd12,   12'd8, 24'hFFFF80, 1'b0, 1'b0};
        tbl[7]  = '{20, 16, 12,   8, 0, 0, 12'd20, 12'd16, 12'd12,   12'd8, 24'hFFFF80, 1'b1, 1'b0};
        tbl[8]  = '{24, 12, 10,   5, 1, 0, 12'd24, 12'd12, 12'd10,   12'd5, 24'h1C03E0, 1'b0, 1'b1};
        tbl[9]  = '{24, 12, 10,   5, 1, 0, 12'd24, 12'd12, 12'd10,   12'd5, 24'h1C03E0, 1'b0, 1'b0};
        tbl[10] = '{24, 12, 10,   5, 1, 0, 12'd24, 12'd12, 12'd10,   12'd5, 24'h1C03E0, 1'b1, 1'b0};
        tbl[11] = '{ 4,  2, 4200, 1, 0, 0, 12'd4,  12'd2,  12'd4095, 12'd1, 24'hFFFFFE, 1'b0, 1'b1};
        tbl[12] = '{24, 12, 10,   5, 0, 0, 12'd24, 12'd12, 12'd10,   12'd5, 24'hFFFFC4, 1'b0, 1'b0};

        reset = 1'b0; vga_clock = 1'b0; hsync = 1'b1; vsync = 1'b1; blank = 1'b0; rgb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ht", h_total, 0);
        check("rst_vt", v_total, 0);
        check("rst_sum", frame_sum, 0);
        check("rst_lock", locked, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", err, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        d0 = done_cnt;
        send_start();
        check("arm_no_done", done_cnt - d0, 0);
        for (int i = 0; i < 13; i++) begin
            send_lines(tbl[i], 0, tbl[i].v_tot - 1);
            d0 = done_cnt; e0 = err_cnt;
            send_start();
            check_frame($sformatf("rec%0d", i), tbl[i], d0, e0);
        end

        // Reset partway through a frame, then resume the same line stream.
        send_lines(tbl[0], 0, 5);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("midrst_ht", h_total, 0);
        check("midrst_ha", h_active, 0);
        check("midrst_vt", v_total, 0);
        check("midrst_va", v_active, 0);
        check("midrst_sum", frame_sum, 0);
        check("midrst_lock", locked, 0);
        send_lines(tbl[0], 6, 11);
        d0 = done_cnt;
        send_start();
        check("midrst_arm_no_done", done_cnt - d0, 0);
        send_lines(tbl[0], 0, 11);
        d0 = done_cnt; e0 = err_cnt;
        send_start();
        check_frame("midrst_full", tbl[0], d0, e0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_capture_monitor.md
Name: vga_capture_monitor

Overview:
- Receive-side counterpart to the team's VGA pattern/sync generators.
- Watches a 640x480-class VGA stream (hsync, vsync, blank, pixel tick, rgb) in the system clock domain.
- Measures line and frame timing, computes a per-frame pixel checksum, and declares lock after consecutive identical frames.
- Used in loopback benches and on-board self-test, between the generator outputs and the DAC pins.

Parameters:
- CNT_W, 12, width of all pixel and line counters; counters saturate at 2^CNT_W-1.
- LOCK_FRAMES, 2, number of consecutive matching frame measurements required to assert locked; range 1..15.
- SYNC_ACT, 0, active level of hsync/vsync; 0 = active-low (640x480 standard).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low.
- vga_clock  in  1  pixel tick, synchronous to clk; one pixel is sampled per 0->1 transition.
- hsync  in  1  horizontal sync.
- vsync  in  1  vertical sync.
- blank  in  1  1 = active video (codebase convention).
- rgb  in  24  pixel data, valid when blank=1.
- h_total  out  CNT_W  pixels per line, last complete line.
- h_active  out  CNT_W  active pixels in last complete line.
- v_total  out  CNT_W  lines per frame, last complete frame.
- v_active  out  CNT_W  lines containing at least one active pixel, last complete frame.
- frame_sum  out  24  sum of rgb over active pixels, last complete frame, mod 2^24.
- frame_done  out  1  one-clk pulse when frame outputs update.
- locked  out  1  timing stable for LOCK_FRAMES frames.
- err  out  1  one-clk pulse when a frame mismatches while locked.

Behaviour:
- Reset (reset=0 at a clk edge): all outputs 0, all counters 0, armed=0, stable count 0; vga_clock_d, hsync_d and vsync_d load the inactive/idle levels.
- Pixel enable: pix_en = vga_clock & ~vga_clock_d, where vga_clock_d is registered every clk. All sampling below happens only on pix_en cycles. hsync_d and vsync_d update only on pix_en.
- Sync edge: h_start = (hsync==SYNC_ACT) & (hsync_d!=SYNC_ACT). v_start is defined the same way on vsync.
- Horizontal counting, per pix_en:
  - h_cnt increments (saturating).
  - If blank=1, ha_cnt increments and line_has_active is set.
  - On h_start: h_total <= h_cnt, h_active <= ha_cnt, then h_cnt <= 1 and ha_cnt <= blank. The sync pixel is counted as pixel 1 of the new line.
- Vertical counting, on h_start:
  - v_cnt increments (saturating).
  - If line_has_active=1, va_cnt increments.
  - line_has_active clears, then reloads from the current blank.
- Checksum: on pix_en with blank=1, sum_acc <= sum_acc + rgb (24-bit wrap).
- Coincident h_start and v_start: the line-end update is applied first, so the ending line is included in v_cnt/va_cnt before the frame latch.
- On v_start:
  - If armed=0: set armed=1, clear v_cnt, va_cnt and sum_acc (these count the new frame's first line as 0), no output update, no frame_done. This discards the partial first frame after reset.
  - If armed=1: v_total <= v_cnt, v_active <= va_cnt, frame_sum <= sum_acc, frame_done=1 on the next clk, then reset the vertical and sum accumulators.
  - Compare {h_total, h_active, v_cnt, va_cnt} against the previous frame's latched set. On match, stable count increments (saturating at LOCK_FRAMES); locked=1 when it reaches LOCK_FRAMES. On mismatch, stable count <= 0 and locked <= 0; err pulses for one clk if locked was 1.
  - The first armed frame has no previous set and counts as a mismatch without err.
- Output latency: frame outputs, frame_done, locked and err all become visible on the clk edge after the v_start pix_en.
- Saturation: if h_cnt or v_cnt saturates, locked drops at the next frame latch (mismatch path). There is no wrap.
- Reset mid-frame: returns to the unarmed state; the next frame is discarded.
- The frame_sum comparison does not affect lock; the pattern content is free to change.

Decomposition:
- Shared package vga_pkg:
  - constants H_TOTAL_640=800, H_ACT_640=640, V_TOTAL_480=525, V_ACT_480=480.
  - pixel width 24.
  - CNT_W default.
- One sub-module, vga_edge_det: registered rising-edge detector used for vga_clock and for both sync inputs, with an enable port and a parameterised idle level.

Test Plan:
- Drive the standard 640x480 generator, vga_clock = clk/2, 3 frames, all active pixels 0xFFFFFF -> at the 2nd frame_done: h_total=800, h_active=640, v_total=525, v_active=480, frame_sum=0xFB5000. locked=1 at the 3rd frame_done (LOCK_FRAMES=2). err never asserts.
- Checkerboard pattern of 32x24 bars -> timing values as above, locked=1; frame_sum is identical on every frame.
- After lock, shorten one line to 799 pixels -> err pulses exactly once and locked=0 at that frame's frame_done. After 2 good frames, locked=1 again.
- Assert reset at line 200 of a frame -> outputs 0 the next clk. The next v_start produces no frame_done; the following one reports full 800/640/525/480.
- Align hsync and vsync active edges on the same pixel -> v_total=525, not 524 or 526.
- Hold vsync inactive for more than 4096 lines -> v_cnt saturates at 4095; on the next v_start, v_total=4095 and locked=0.
